// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt request controller: vector width,
// internal exception bits and register reset values.
package int_ctrl_pkg;

  localparam int N_IRQ = 8;

  localparam logic [N_IRQ-1:0] EXC_ALU   = 8'b0000_0001;
  localparam logic [N_IRQ-1:0] EXC_STACK = 8'b0000_0010;
  localparam logic [N_IRQ-1:0] EXC_MASK  = EXC_ALU | EXC_STACK;

  localparam logic [N_IRQ-1:0] MASK_RST    = 8'h00;
  localparam logic [N_IRQ-1:0] PENDING_RST = 8'h00;
  localparam logic [N_IRQ-1:0] ACTIVE_RST  = 8'h00;

endpackage

// File: rtl/int_ctrl_if.sv
// Request, mask and acknowledge signals between the interrupt controller and
// the control unit; master drives requests/acks, slave is the controller.
interface int_ctrl_if;
  import int_ctrl_pkg::N_IRQ;

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_d;
  logic [N_IRQ-1:0] s_calli;
  logic [N_IRQ-1:0] s_reti;
  logic [N_IRQ-1:0] min_bit_s;
  logic [N_IRQ-1:0] min_bit_a;
  logic [N_IRQ-1:0] int_a;
  logic [N_IRQ-1:0] pending;

  modport master (
    output irq_in, mask_we, mask_d, s_calli, s_reti,
    input  min_bit_s, min_bit_a, int_a, pending
  );

  modport slave (
    input  irq_in, mask_we, mask_d, s_calli, s_reti,
    output min_bit_s, min_bit_a, int_a, pending
  );

endinterface

// File: rtl/int_ctrl_lsb_onehot.sv
// Isolates the lowest set bit of x as a one-hot vector (0 when x is 0).
// Purely combinational, no latency, no flow control.
module lsb_onehot
  import int_ctrl_pkg::N_IRQ;
(
  input  logic [N_IRQ-1:0] x,
  output logic [N_IRQ-1:0] y
);

  assign y = x & (~x + {{(N_IRQ-1){1'b0}}, 1'b1});

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-captured pending set, in-service set, lowest-bit
// priority vectors; all outputs registered. INT_CTRL_SYNC_EN adds a 2-flop irq_in synchronizer.
module int_ctrl #(
  parameter int                                N_IRQ    = int_ctrl_pkg::N_IRQ,
  parameter logic [int_ctrl_pkg::N_IRQ-1:0]    EXC_MASK = int_ctrl_pkg::EXC_MASK
) (
  input  logic      clk,
  input  logic      reset,
  int_ctrl_if.slave bus
);
  import int_ctrl_pkg::MASK_RST;
  import int_ctrl_pkg::PENDING_RST;
  import int_ctrl_pkg::ACTIVE_RST;

  logic [N_IRQ-1:0] irq_sync;
  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] irq_prev_q,  irq_prev_d;
  logic [N_IRQ-1:0] pending_q,   pending_d;
  logic [N_IRQ-1:0] active_q,    active_d;
  logic [N_IRQ-1:0] en_mask_q,   en_mask_d;
  logic [N_IRQ-1:0] pend_en;

`ifdef INT_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync1_d;
  logic [N_IRQ-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_sync = sync2_q;
`else
  assign irq_sync = bus.irq_in;
`endif

  // Set terms are OR-ed last so a new request or entry wins over a same-cycle clear.
  always_comb begin
    irq_edge   = irq_sync & ~irq_prev_q & ~EXC_MASK;
    irq_prev_d = irq_sync;
    pending_d  = (pending_q & ~bus.s_calli) | irq_edge;
    active_d   = (active_q & ~bus.s_reti) | bus.s_calli;
    en_mask_d  = bus.mask_we ? bus.mask_d : en_mask_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q <= '0;
      pending_q  <= PENDING_RST;
      active_q   <= ACTIVE_RST;
      en_mask_q  <= MASK_RST;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      en_mask_q  <= en_mask_d;
    end
  end

  // Outputs depend only on flops, so the control unit's acks never loop back combinationally.
  assign pend_en     = pending_q & en_mask_q;
  assign bus.pending = pending_q;
  assign bus.int_a   = active_q;

  lsb_onehot u_min_s (
    .x (pend_en),
    .y (bus.min_bit_s)
  );

  lsb_onehot u_min_a (
    .x (active_q),
    .y (bus.min_bit_a)
  );

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboarded random + directed bench for int_ctrl; a bit-level reference
// model predicts every cycle's outputs, a monitor pops and compares them.
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [7:0] pend;
    logic [7:0] act;
    logic [7:0] mbs;
    logic [7:0] mba;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t       exp_q[$];
  logic [7:0] dly[$];
  logic [7:0] m_pend, m_act, m_mask, m_prev;
  logic [7:0] last_irq;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp;
    exp_t e;
    e.pend = m_pend;
    e.act  = m_act;
    e.mbs  = lowest(m_pend & m_mask);
    e.mba  = lowest(m_act);
    exp_q.push_back(e);
  endtask

  task automatic model_clear;
    dly.delete();
    for (int i = 0; i < LAT; i++) dly.push_back(8'h00);
    m_pend = 8'h00;
    m_act  = 8'h00;
    m_mask = 8'h00;
    m_prev = 8'h00;
  endtask

  // One clock with reset released: drive at negedge, predict the post-edge state.
  task automatic step(input logic [7:0] irq, input logic mwe, input logic [7:0] md,
                      input logic [7:0] calli, input logic [7:0] reti);
    logic [7:0] seen;
    @(negedge clk);
    reset       = 1'b1;
    bus.irq_in  = irq;
    bus.mask_we = mwe;
    bus.mask_d  = md;
    bus.s_calli = calli;
    bus.s_reti  = reti;
    last_irq    = irq;
    dly.push_back(irq);
    seen = dly.pop_front();
    for (int i = 0; i < 8; i++) begin
      // bits 0 and 1 belong to internal exceptions and never become pending
      if (i >= 2 && seen[i] && !m_prev[i]) m_pend[i] = 1'b1;
      else if (calli[i])                   m_pend[i] = 1'b0;
      if (calli[i])     m_act[i] = 1'b1;
      else if (reti[i]) m_act[i] = 1'b0;
    end
    m_prev = seen;
    if (mwe) m_mask = md;
    push_exp();
  endtask

  task automatic rst_step(input logic [7:0] irq);
    @(negedge clk);
    reset       = 1'b0;
    bus.irq_in  = irq;
    bus.mask_we = 1'b1;
    bus.mask_d  = 8'hFF;
    bus.s_calli = 8'hFF;
    bus.s_reti  = 8'h00;
    last_irq    = irq;
    model_clear();
    push_exp();
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("sb_pending",   bus.pending,   e.pend);
        cmp("sb_int_a",     bus.int_a,     e.act);
        cmp("sb_min_bit_s", bus.min_bit_s, e.mbs);
        cmp("sb_min_bit_a", bus.min_bit_a, e.mba);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] irq, calli, reti;
    int r;
    reset       = 1'b0;
    bus.irq_in  = 8'h00;
    bus.mask_we = 1'b0;
    bus.mask_d  = 8'h00;
    bus.s_calli = 8'h00;
    bus.s_reti  = 8'h00;
    last_irq    = 8'h00;
    model_clear();

    // Reset held: toggling requests must leave everything at zero.
    rst_step(8'hFF);
    rst_step(8'h00);
    rst_step(8'hF0);
    settle();
    cmp("rst_pending", bus.pending,   8'h00);
    cmp("rst_int_a",   bus.int_a,     8'h00);
    cmp("rst_min_s",   bus.min_bit_s, 8'h00);
    rst_step(8'h00);
    for (int i = 0; i <= LAT; i++) step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    step(8'h00, 1'b1, 8'hFC, 8'h00, 8'h00);

    // Capture, entry, return.
    for (int i = 0; i <= LAT; i++) step(8'h10, 1'b0, 8'h00, 8'h00, 8'h00);
    settle();
    cmp("cap_pending", bus.pending,   8'h10);
    cmp("cap_min_s",   bus.min_bit_s, 8'h10);
    step(8'h10, 1'b0, 8'h00, 8'h10, 8'h00);
    settle();
    cmp("entry_pending", bus.pending,   8'h00);
    cmp("entry_int_a",   bus.int_a,     8'h10);
    cmp("entry_min_a",   bus.min_bit_a, 8'h10);
    for (int i = 0; i <= LAT; i++) step(8'h10, 1'b0, 8'h00, 8'h00, 8'h00);
    settle();
    cmp("held_pending", bus.pending, 8'h00);
    step(8'h10, 1'b0, 8'h00, 8'h00, 8'h10);
    settle();
    cmp("ret_int_a", bus.int_a, 8'h00);

    // Nesting: bit 2 preempts bit 4.
    step(8'h10, 1'b0, 8'h00, 8'h10, 8'h00);
    for (int i = 0; i <= LAT; i++) step(8'h14, 1'b0, 8'h00, 8'h00, 8'h00);
    settle();
    cmp("nest_min_s", bus.min_bit_s, 8'h04);
    step(8'h14, 1'b0, 8'h00, 8'h04, 8'h00);
    settle();
    cmp("nest_int_a", bus.int_a,     8'h14);
    cmp("nest_min_a", bus.min_bit_a, 8'h04);
    step(8'h14, 1'b0, 8'h00, 8'h00, 8'h04);
    settle();
    cmp("unnest_min_a", bus.min_bit_a, 8'h10);
    step(8'h00, 1'b1, 8'hF8, 8'h00, 8'h10);

    // Masking and internal exceptions.
    for (int i = 0; i <= LAT; i++) step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i <= LAT; i++) step(8'h04, 1'b0, 8'h00, 8'h00, 8'h00);
    settle();
    cmp("masked_pending", bus.pending,   8'h04);
    cmp("masked_min_s",   bus.min_bit_s, 8'h00);
    step(8'h04, 1'b1, 8'hFC, 8'h00, 8'h00);
    settle();
    cmp("unmask_min_s", bus.min_bit_s, 8'h04);
    for (int i = 0; i <= LAT; i++) step(8'h05, 1'b0, 8'h00, 8'h00, 8'h00);
    settle();
    cmp("exc_pending", bus.pending, 8'h04);
    step(8'h05, 1'b0, 8'h00, 8'h01, 8'h00);
    settle();
    cmp("exc_int_a", bus.int_a, 8'h01);
    step(8'h00, 1'b0, 8'h00, 8'h00, 8'h01);

    // Same-cycle new edge and entry on bit 5: set wins in pending.
    for (int i = 0; i <= LAT; i++) step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i <= LAT; i++) step(8'h20, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i <= LAT; i++) step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i <= LAT; i++)
      step(8'h20, 1'b0, 8'h00, (i == LAT) ? 8'h20 : 8'h00, 8'h00);
    settle();
    cmp("simul_pending5", {7'd0, bus.pending[5]}, 8'h01);
    cmp("simul_int_a5",   {7'd0, bus.int_a[5]},   8'h01);

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_step(8'($urandom));
        continue;
      end
      irq = last_irq ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      r = $urandom_range(0, 19);
      if (r < 3)       calli = lowest(m_pend & m_mask);
      else if (r < 6)  calli = 8'(1 << $urandom_range(0, 7));
      else if (r == 6) calli = 8'($urandom);
      else             calli = 8'h00;
      r = $urandom_range(0, 19);
      if (r < 3)       reti = lowest(m_act);
      else if (r < 5)  reti = 8'(1 << $urandom_range(0, 7));
      else if (r == 5) reti = 8'($urandom);
      else             reti = 8'h00;
      step(irq, ($urandom_range(0, 9) == 0), 8'($urandom), calli, reti);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt request controller that feeds the control unit's interrupt inputs. It captures rising edges on peripheral request lines and holds them as pending requests. It keeps the in-service (active) set and presents the one-hot lowest pending and lowest active bits. It consumes the control unit's acknowledge vectors: `s_calli` for entry and `s_reti` for return. It sits beside the control unit in the CPU top and closes the interrupt loop.

## Interface
Parameters:
- `N_IRQ`, 8: number of request lines. Fixed to the 8-bit control-unit vector width.
- `EXC_MASK`, 8'b0000_0011: bits reserved for internal exceptions (ALU overflow = bit 0, stack overflow = bit 1). These bits are never pending.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. All registers clear while low.
- `irq_in` in 8: peripheral request lines. A rising edge requests service. Bits in `EXC_MASK` are ignored.
- `mask_we` in 1: loads `mask_d` into the enable mask at the next edge.
- `mask_d` in 8: new enable mask (1 = enabled).
- `s_calli` in 8: one-hot interrupt-entry acknowledge from the control unit, 0 when idle.
- `s_reti` in 8: one-hot return acknowledge from the control unit, 0 when idle.
- `min_bit_s` out 8: one-hot lowest set bit of `pending & mask`, 0 if none.
- `min_bit_a` out 8: one-hot lowest set bit of `active`, 0 if none.
- `int_a` out 8: full active (in-service) register.
- `pending` out 8: raw pending register, unmasked.

## Operation
- Priority: a lower bit index has higher priority. The control unit preempts when `min_bit_s` is numerically below `min_bit_a`, or when `min_bit_a` = 0 and `min_bit_s` ≠ 0. This block only presents the two vectors.
- Edge detect: `edge = irq_sync & ~irq_prev & ~EXC_MASK`. `irq_prev` is a register of `irq_sync`.
- Pending update each edge: `pending <= (pending & ~s_calli) | edge`.
  - Set wins over clear when both hit the same bit in the same cycle, so the new request is retained.
  - A repeated edge while a request is already pending merges with it; there is no counting.
- Masking: masked bits stay pending and remain visible on `pending`. They appear on `min_bit_s` once the bit is enabled.
- Active update each edge: `active <= (active & ~s_reti) | s_calli`.
  - If the same bit is in both `s_calli` and `s_reti`, the set (`s_calli`) wins.
  - `s_calli` = 8'b1 or 8'b10 (internal exceptions) sets `active[0]` or `active[1]` with no pending bit involved.
- Nesting: `active` can hold several bits (nested preemption). `s_reti` clears only the bit it names.
- Non-one-hot acknowledges: the update equations above are applied bitwise. No error is raised.
- Combinational-loop rule: `min_bit_s`, `min_bit_a`, `int_a` and `pending` come only from registers. There is no combinational path from `s_calli` or `s_reti` to any output, so no loop forms through the control unit.

## Timing
- Reset values: `pending` = 0, `active` = 0, `mask` = 8'h00, synchronizer and `irq_prev` = 0. Therefore `min_bit_s` = `min_bit_a` = `int_a` = `pending` = 0.
- Request latency with `INT_CTRL_SYNC_EN`: `irq_in` rises before edge k → `pending` bit set after edge k+2 → `min_bit_s` valid in cycle k+2..k+3 (when enabled).
- Request latency without `INT_CTRL_SYNC_EN`: `pending` bit set after edge k.
- Acknowledge: `s_calli` sampled at edge j. After edge j, the `pending` bit is clear and the `active` bit is set, so `min_bit_s` drops and `min_bit_a` updates. This is a one-cycle handshake.
- Return: `s_reti` sampled at edge j → `active` bit clear after edge j.
- Mask write: takes effect after the edge at which `mask_we` is sampled high.
- Reset mid-operation: reset asserted at any time clears pending and active immediately. Requests in flight in the synchronizer are lost.

## Configuration
- `INT_CTRL_SYNC_EN` defined: a two-flop synchronizer sits on `irq_in` before edge detection. Latency is as stated in Timing.
- `INT_CTRL_SYNC_EN` undefined: `irq_in` drives `irq_sync` directly (inputs must be synchronous to `clk`). Latency is reduced by 2 cycles. All other behaviour is identical.

## Structure
- Shared package holds:
  - `N_IRQ`.
  - `EXC_ALU` = 8'b1 and `EXC_STACK` = 8'b10.
  - `EXC_MASK`.
  - Reset constants for `mask`, `pending` and `active`.
- One sub-module, `lsb_onehot`: 8-bit lowest-set-bit isolator, `y = x & (~x + 1)`, purely combinational. It is instantiated twice, once for `min_bit_s` and once for `min_bit_a`.

## Test plan
- Reset behaviour: with `reset` low, toggle `irq_in` → all outputs stay 0. Release reset, write `mask` = 8'hFC.
- Request capture: `irq_in[4]` rises → `pending` = 8'h10 and `min_bit_s` = 8'h10 after 3 edges (sync build). Hold `irq_in` high → no new set after acknowledge.
- Entry and return: `s_calli` = 8'h10 for one cycle → next cycle `pending` = 0, `int_a` = 8'h10, `min_bit_a` = 8'h10. Then `s_reti` = 8'h10 → `int_a` = 0.
- Nesting and priority: active = 8'h10, then `irq_in[2]` edge → `min_bit_s` = 8'h04. `s_calli` = 8'h04 → `int_a` = 8'h14, `min_bit_a` = 8'h04. `s_reti` = 8'h04 → `min_bit_a` = 8'h10.
- Masking and exceptions:
  - `mask` = 8'hF8 with `irq_in[2]` edge → `pending` = 8'h04, `min_bit_s` = 0. Write `mask` = 8'hFC → `min_bit_s` = 8'h04.
  - `irq_in[0]` edge → `pending` unchanged.
  - `s_calli` = 8'h01 → `int_a[0]` = 1.
- Simultaneous set and clear: new `irq_in[5]` edge in the same cycle as `s_calli` = 8'h20 → `pending[5]` = 1 and `int_a[5]` = 1 after the edge.
